// File: rtl/find_topk.sv
`default_nettype none
// =============================================================================
// Module      : find_topk
// Description : Scans a frame of NUM_VALUES signed candidates (each carrying a
//               payload word) and keeps a sorted list of the K best ones,
//               minimum or maximum as selected by mode_max. At the end of the
//               frame the K results are streamed best-first over valid/ready.
//               No new frame is accepted until the results have drained.
//
// Ports       : clk, rst_n               clock, asynchronous active-low reset
//               mode_max                 0 = minima, 1 = maxima (latched on
//                                        the first accept of a frame)
//               frame_abort              drop current frame / drain
//               in_valid/in_ready        candidate handshake
//               in_value, in_payload     signed candidate and its payload
//               out_valid/out_ready      result handshake
//               out_value, out_payload   result value and payload
//               out_index                arrival index + IDX_BASE
//               out_rank, out_last       0 = best; last flags rank K-1
//               busy                     frame accepted but not yet drained
//
// Options     : TIE_LAST_EN  when defined, on equal values the later arrival
//                            ranks better (default: earlier arrival wins)
//
// Revision    : 1.0 - initial release
// =============================================================================
module find_topk #(
    parameter int N          = 32,
    parameter int PW         = 128,
    parameter int NUM_VALUES = 16,
    parameter int K          = 4,
    parameter int IDX_BASE   = 1,
    parameter int IW         = $clog2(NUM_VALUES + IDX_BASE)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode_max,
    input  logic                frame_abort,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        in_value,
    input  logic [PW-1:0]       in_payload,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_value,
    output logic [PW-1:0]       out_payload,
    output logic [IW-1:0]       out_index,
    output logic [$clog2(K):0]  out_rank,
    output logic                out_last,
    output logic                busy
);

    localparam int               c_rw         = $clog2(K) + 1;
    localparam int               c_sw         = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0]    c_last_count = IW'(NUM_VALUES - 1);
    localparam logic [IW-1:0]    c_idx_base   = IW'(IDX_BASE);
    localparam logic [c_rw-1:0]  c_last_rank  = c_rw'(K - 1);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [IW-1:0]        r_count;
    logic [c_rw-1:0]      r_rank;
    logic                 r_mode;
    logic                 r_busy;

    logic                 w_accept;
    logic                 w_out_hs;
    logic                 w_drain_done;
    logic                 w_mode;
    logic signed [N-1:0]  w_new_val;
    logic [IW-1:0]        w_new_idx;
    logic [c_sw-1:0]      w_sel;

    // Flattened view of the list, slot 0 = best
    logic signed [N-1:0]  w_val [K];
    logic [PW-1:0]        w_pay [K];
    logic [IW-1:0]        w_idx [K];
    logic [K-1:0]         w_vld;
    logic [K-1:0]         w_better;

    // Handshakes are decoded from the state register directly so the FSM
    // process does not read back its own outputs.
    assign w_accept     = in_valid & (r_state == ACCUM) & ~frame_abort;
    assign w_out_hs     = out_ready & (r_state == DRAIN);
    assign w_drain_done = w_out_hs & (r_rank == c_last_rank) & ~frame_abort;

    // On the first sample of a frame the live pin decides the mode
    assign w_mode    = (r_count == '0) ? mode_max : r_mode;
    assign w_new_val = $signed(in_value);
    assign w_new_idx = r_count + c_idx_base;

    // -------------------------------------------------------------------------
    // State machine
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        case (r_state)
            ACCUM: begin
                in_ready = 1'b1;
                if (w_accept && (r_count == c_last_count)) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (r_rank == c_last_rank);
                if (w_drain_done) begin
                    w_state_next = ACCUM;
                end
            end
            default: w_state_next = ACCUM;
        endcase
        if (frame_abort) begin
            w_state_next = ACCUM;
        end
    end

    // -------------------------------------------------------------------------
    // Frame counter, drain pointer, latched mode, busy flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_rank  <= '0;
            r_mode  <= 1'b0;
            r_busy  <= 1'b0;
        end else if (frame_abort) begin
            r_count <= '0;
            r_rank  <= '0;
            r_busy  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_busy  <= 1'b1;
                r_count <= (r_count == c_last_count) ? '0 : r_count + 1'b1;
                if (r_count == '0) begin
                    r_mode <= mode_max;
                end
            end
            if (w_out_hs) begin
                if (r_rank == c_last_rank) begin
                    r_rank <= '0;
                    r_busy <= 1'b0;
                end else begin
                    r_rank <= r_rank + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sorted insertion list. Because the list is kept sorted with invalid
    // slots at the tail, w_better is monotonic: once a slot is beaten, every
    // slot below it is too. The insertion point is therefore the first slot
    // whose upper neighbour is not beaten; deeper beaten slots take their
    // upper neighbour, which shifts the tail down and drops slot K-1.
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < K; i++) begin : g_slot
        logic signed [N-1:0]  r_val;
        logic [PW-1:0]        r_pay;
        logic [IW-1:0]        r_idx;
        logic                 r_vld;
        logic                 w_wins;
        logic signed [N-1:0]  w_in_val;
        logic [PW-1:0]        w_in_pay;
        logic [IW-1:0]        w_in_idx;
        logic                 w_in_vld;

`ifdef TIE_LAST_EN
        assign w_wins = w_mode ? (w_new_val >= r_val) : (w_new_val <= r_val);
`else
        assign w_wins = w_mode ? (w_new_val > r_val) : (w_new_val < r_val);
`endif
        assign w_better[i] = ~r_vld | w_wins;

        if (i == 0) begin : g_head
            assign w_in_val = w_new_val;
            assign w_in_pay = in_payload;
            assign w_in_idx = w_new_idx;
            assign w_in_vld = 1'b1;
        end else begin : g_body
            assign w_in_val = w_better[i-1] ? w_val[i-1] : w_new_val;
            assign w_in_pay = w_better[i-1] ? w_pay[i-1] : in_payload;
            assign w_in_idx = w_better[i-1] ? w_idx[i-1] : w_new_idx;
            assign w_in_vld = w_better[i-1] ? w_vld[i-1] : 1'b1;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_val <= '0;
                r_pay <= '0;
                r_idx <= '0;
                r_vld <= 1'b0;
            end else if (frame_abort || w_drain_done) begin
                r_vld <= 1'b0;
            end else if (w_accept && w_better[i]) begin
                r_val <= w_in_val;
                r_pay <= w_in_pay;
                r_idx <= w_in_idx;
                r_vld <= w_in_vld;
            end
        end

        assign w_val[i] = r_val;
        assign w_pay[i] = r_pay;
        assign w_idx[i] = r_idx;
        assign w_vld[i] = r_vld;
    end

    // -------------------------------------------------------------------------
    // Result presentation
    // -------------------------------------------------------------------------
    assign w_sel       = r_rank[c_sw-1:0];
    assign out_value   = w_val[w_sel];
    assign out_payload = w_pay[w_sel];
    assign out_index   = w_idx[w_sel];
    assign out_rank    = r_rank;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_find_topk.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module      : tb_find_topk
// Description : Directed self-checking bench for find_topk. Three instances
//               share the stimulus bus; sel picks which one is driven and
//               observed: 0 = K3 (N=32), 1 = K4 (N=32), 2 = K2 (N=8).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_find_topk;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [1:0]   sel;
    logic         mode_max;
    logic         frame_abort;
    logic         in_valid;
    logic         out_ready;
    logic [31:0]  in_value;
    logic [127:0] in_payload;

    logic a_in_ready, a_out_valid, a_out_last, a_busy;
    logic [31:0] a_out_value; logic [127:0] a_out_payload;
    logic [4:0] a_out_index;  logic [2:0] a_out_rank;

    logic b_in_ready, b_out_valid, b_out_last, b_busy;
    logic [31:0] b_out_value; logic [127:0] b_out_payload;
    logic [4:0] b_out_index;  logic [2:0] b_out_rank;

    logic c_in_ready, c_out_valid, c_out_last, c_busy;
    logic [7:0] c_out_value;  logic [127:0] c_out_payload;
    logic [4:0] c_out_index;  logic [1:0] c_out_rank;

    find_topk #(.N(32), .PW(128), .NUM_VALUES(16), .K(3), .IDX_BASE(1)) u_k3 (
        .clk(clk), .rst_n(rst_n), .mode_max(mode_max),
        .frame_abort(frame_abort && (sel == 2'd0)),
        .in_valid(in_valid && (sel == 2'd0)), .in_ready(a_in_ready),
        .in_value(in_value), .in_payload(in_payload),
        .out_valid(a_out_valid), .out_ready(out_ready && (sel == 2'd0)),
        .out_value(a_out_value), .out_payload(a_out_payload),
        .out_index(a_out_index), .out_rank(a_out_rank),
        .out_last(a_out_last), .busy(a_busy));

    find_topk #(.N(32), .PW(128), .NUM_VALUES(16), .K(4), .IDX_BASE(1)) u_k4 (
        .clk(clk), .rst_n(rst_n), .mode_max(mode_max),
        .frame_abort(frame_abort && (sel == 2'd1)),
        .in_valid(in_valid && (sel == 2'd1)), .in_ready(b_in_ready),
        .in_value(in_value), .in_payload(in_payload),
        .out_valid(b_out_valid), .out_ready(out_ready && (sel == 2'd1)),
        .out_value(b_out_value), .out_payload(b_out_payload),
        .out_index(b_out_index), .out_rank(b_out_rank),
        .out_last(b_out_last), .busy(b_busy));

    find_topk #(.N(8), .PW(128), .NUM_VALUES(16), .K(2), .IDX_BASE(1)) u_n8 (
        .clk(clk), .rst_n(rst_n), .mode_max(mode_max),
        .frame_abort(frame_abort && (sel == 2'd2)),
        .in_valid(in_valid && (sel == 2'd2)), .in_ready(c_in_ready),
        .in_value(in_value[7:0]), .in_payload(in_payload),
        .out_valid(c_out_valid), .out_ready(out_ready && (sel == 2'd2)),
        .out_value(c_out_value), .out_payload(c_out_payload),
        .out_index(c_out_index), .out_rank(c_out_rank),
        .out_last(c_out_last), .busy(c_busy));

    // Observed outputs of the selected instance
    logic         obs_in_ready, obs_valid, obs_last, obs_busy;
    logic [31:0]  obs_value, obs_index, obs_rank;
    logic [127:0] obs_payload;

    always_comb begin
        obs_in_ready = a_in_ready;
        obs_valid    = a_out_valid;
        obs_last     = a_out_last;
        obs_busy     = a_busy;
        obs_value    = a_out_value;
        obs_index    = {27'd0, a_out_index};
        obs_rank     = {29'd0, a_out_rank};
        obs_payload  = a_out_payload;
        if (sel == 2'd1) begin
            obs_in_ready = b_in_ready;
            obs_valid    = b_out_valid;
            obs_last     = b_out_last;
            obs_busy     = b_busy;
            obs_value    = b_out_value;
            obs_index    = {27'd0, b_out_index};
            obs_rank     = {29'd0, b_out_rank};
            obs_payload  = b_out_payload;
        end else if (sel == 2'd2) begin
            obs_in_ready = c_in_ready;
            obs_valid    = c_out_valid;
            obs_last     = c_out_last;
            obs_busy     = c_busy;
            obs_value    = {{24{c_out_value[7]}}, c_out_value};
            obs_index    = {27'd0, c_out_index};
            obs_rank     = {30'd0, c_out_rank};
            obs_payload  = c_out_payload;
        end
    end

    int           vectors;
    int           miscompares;
    int           rdy_bad;
    int           low_cnt;
    int           vals [16];
    int           got_val [4];
    int           got_idx [4];
    int           got_rank [4];
    logic         got_last [4];
    logic [127:0] got_pay [4];
    int           e0;
    int           e1;

    function automatic logic [127:0] pay(input int i, input int v);
        return {32'(i), 32'(v * 3), 32'hC0FFEE00, 32'(v)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d (0x%08h), expected %0d (0x%08h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%032h, expected 0x%032h", tag, obs, exp);
        end
    endtask

    // Sends vals[first .. last-1]; mode pin is flipped after sample 0 to
    // confirm it is only sampled on the first accept of a frame.
    task automatic send(input int first, input int last, input logic m);
        for (int i = first; i < last; i++) begin
            in_valid   = 1'b1;
            in_value   = 32'(vals[i]);
            in_payload = pay(i, vals[i]);
            mode_max   = (i == 0) ? m : ~m;
            if (obs_in_ready !== 1'b1) rdy_bad++;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int k);
        int n   = 0;
        int cyc = 0;
        low_cnt   = 0;
        out_ready = 1'b1;
        while (n < k && cyc < 64) begin
            if (obs_in_ready == 1'b0) low_cnt++;
            if (obs_valid) begin
                got_val[n]  = obs_value;
                got_idx[n]  = obs_index;
                got_rank[n] = obs_rank;
                got_last[n] = obs_last;
                got_pay[n]  = obs_payload;
                n++;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_results", n, k);
    endtask

    task automatic expect_out(input string tag, input int v, input int idx,
                              input int rank, input logic last);
        chk({tag, "_valid"}, obs_valid, 1);
        chk({tag, "_value"}, obs_value, v);
        chk({tag, "_index"}, obs_index, idx);
        chk({tag, "_rank"},  obs_rank, rank);
        chk({tag, "_last"},  obs_last, last);
        chk_w({tag, "_payload"}, obs_payload, pay(idx - 1, v));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; miscompares = 0; rdy_bad = 0;
        rst_n = 1'b0; sel = 2'd0; mode_max = 1'b0; frame_abort = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_value = '0; in_payload = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_in_ready", obs_in_ready, 1);
        chk("rst_out_valid", obs_valid, 0);
        chk("rst_busy", obs_busy, 0);
        chk("rst_last", obs_last, 0);
        chk("rst_value", obs_value, 0);
        chk("rst_index", obs_index, 0);
        chk("rst_rank", obs_rank, 0);
        chk_w("rst_payload", obs_payload, '0);
        rst_n = 1'b1;
        tick();

        // ---- Min mode, K=3, with a tie at -3 ----
        for (int i = 0; i < 16; i++) vals[i] = 100;
        vals[5] = -3; vals[9] = 7; vals[12] = -3;
        send(0, 1, 1'b0);
        chk("min_busy_after_first", obs_busy, 1);
        send(1, 16, 1'b0);
        chk("min_ready_in_frame", rdy_bad, 0);
        chk("min_valid_after_last", obs_valid, 1);
        drain(3);
        chk("min_ready_low_cycles", low_cnt, 3);
        chk("min_ready_after", obs_in_ready, 1);
        chk("min_busy_after", obs_busy, 0);
`ifdef TIE_LAST_EN
        e0 = 13; e1 = 6;
`else
        e0 = 6; e1 = 13;
`endif
        chk("min_r0_value", got_val[0], -3);
        chk("min_r0_index", got_idx[0], e0);
        chk("min_r1_value", got_val[1], -3);
        chk("min_r1_index", got_idx[1], e1);
        chk("min_r2_value", got_val[2], 7);
        chk("min_r2_index", got_idx[2], 10);
        chk("min_r0_rank", got_rank[0], 0);
        chk("min_r2_rank", got_rank[2], 2);
        chk("min_r0_last", got_last[0], 0);
        chk("min_r1_last", got_last[1], 0);
        chk("min_r2_last", got_last[2], 1);
        chk_w("min_r0_payload", got_pay[0], pay(e0 - 1, -3));
        chk_w("min_r2_payload", got_pay[2], pay(9, 7));

        // ---- Max mode, K=4, ascending values, stalled drain ----
        sel = 2'd1; rdy_bad = 0;
        for (int i = 0; i < 16; i++) vals[i] = i;
        send(0, 16, 1'b1);
        chk("max_ready_in_frame", rdy_bad, 0);
        out_ready = 1'b1; expect_out("max_r0", 15, 16, 0, 1'b0); tick();
        out_ready = 1'b0; expect_out("max_r1_stall_a", 14, 15, 1, 1'b0); tick();
        out_ready = 1'b0; expect_out("max_r1_stall_b", 14, 15, 1, 1'b0); tick();
        out_ready = 1'b1; expect_out("max_r1", 14, 15, 1, 1'b0); tick();
        expect_out("max_r2", 13, 14, 2, 1'b0); tick();
        expect_out("max_r3", 12, 13, 3, 1'b1); tick();
        out_ready = 1'b0;
        chk("max_ready_after", obs_in_ready, 1);
        chk("max_valid_after", obs_valid, 0);
        chk("max_busy_after", obs_busy, 0);

        // ---- Abort after 7 accepts; abort-cycle sample must be ignored ----
        sel = 2'd0; rdy_bad = 0;
        for (int i = 0; i < 16; i++) vals[i] = -500 - i;
        send(0, 7, 1'b1);
        chk("abort_busy_before", obs_busy, 1);
        in_valid = 1'b1; in_value = 32'(-999); in_payload = pay(99, -999);
        frame_abort = 1'b1;
        tick();
        frame_abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", obs_busy, 0);
        chk("abort_ready", obs_in_ready, 1);
        chk("abort_valid", obs_valid, 0);
        for (int i = 0; i < 16; i++) vals[i] = 200 - 10 * i;
        send(0, 16, 1'b0);
        chk("abort_ready_in_frame", rdy_bad, 0);
        chk("abort_valid_after_last", obs_valid, 1);
        drain(3);
        chk("abort_r0_value", got_val[0], 50);
        chk("abort_r0_index", got_idx[0], 16);
        chk("abort_r1_value", got_val[1], 60);
        chk("abort_r2_value", got_val[2], 70);
        chk("abort_r2_index", got_idx[2], 14);

        // ---- Reset in the middle of a drain ----
        for (int i = 0; i < 16; i++) vals[i] = 2 * i;
        send(0, 16, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("mid_drain_rank1", obs_rank, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", obs_valid, 0);
        chk("rstmid_ready", obs_in_ready, 1);
        chk("rstmid_busy", obs_busy, 0);
        chk("rstmid_value", obs_value, 0);
        chk("rstmid_rank", obs_rank, 0);
        chk("rstmid_index", obs_index, 0);
        chk("rstmid_last", obs_last, 0);
        chk_w("rstmid_payload", obs_payload, '0);
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) vals[i] = 30 - i;
        send(0, 16, 1'b0);
        drain(3);
        chk("post_rst_r0_value", got_val[0], 15);
        chk("post_rst_r0_index", got_idx[0], 16);
        chk("post_rst_r2_value", got_val[2], 17);
        chk("post_rst_r2_index", got_idx[2], 14);

        // ---- N=8 signed extremes ----
        sel = 2'd2; rdy_bad = 0;
        for (int i = 0; i < 16; i++) vals[i] = i - 5;
        vals[3] = -128; vals[10] = 127;
        send(0, 16, 1'b0);
        drain(2);
        chk("n8_min_r0_value", got_val[0], -128);
        chk("n8_min_r0_index", got_idx[0], 4);
        chk("n8_min_r1_value", got_val[1], -5);
        chk("n8_min_r1_index", got_idx[1], 1);
        chk("n8_min_r1_last", got_last[1], 1);
        send(0, 16, 1'b1);
        drain(2);
        chk("n8_max_r0_value", got_val[0], 127);
        chk("n8_max_r0_index", got_idx[0], 11);
        chk("n8_max_r1_value", got_val[1], 10);
        chk("n8_max_r1_index", got_idx[1], 16);
        chk("n8_ready_in_frames", rdy_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/find_topk.md
Name: find_topk

Overview:
- Parametrised successor to the single-minimum search block.
- Scans a frame of NUM_VALUES signed candidates, each with a payload word.
- Keeps a sorted list of the K best candidates. Mode selects minimum or maximum.
- Streams the K results, best first, over a valid/ready handshake. Sits after the dq metric stage, ahead of symbol decision / soft-output logic.

Parameters:
- N, 32: candidate value width (signed).
- PW, 128: payload width (e.g. packed m_dI1/m_dI2/m_dQ1/m_dQ2).
- NUM_VALUES, 16: candidates per frame, ≥2.
- K, 4: results kept, 1 ≤ K ≤ NUM_VALUES.
- IDX_BASE, 1: offset added to 0-based arrival index on out_index.
- IW, $clog2(NUM_VALUES+IDX_BASE): index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mode_max  in  1  0 = find minima, 1 = find maxima; sampled on first accepted sample of frame
- frame_abort  in  1  discard current frame/drain
- in_valid  in  1  candidate valid
- in_ready  out  1  block accepts candidate
- in_value  in  N  signed candidate
- in_payload  in  PW  payload travelling with candidate
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_value  out  N  result value
- out_payload  out  PW  result payload
- out_index  out  IW  arrival index + IDX_BASE
- out_rank  out  $clog2(K)+1  0 = best
- out_last  out  1  high with rank K-1
- busy  out  1  frame in progress (≥1 sample accepted, not yet fully drained)

Behaviour:
- Reset values: all outputs 0, except in_ready = 1. List entries invalid, count = 0, state ACCUM.
- States:
  - ACCUM: in_ready = 1, out_valid = 0.
  - DRAIN: in_ready = 0, out_valid = 1.
- Accept on in_valid & in_ready. Accept #0 latches mode_max and sets busy.
- Insertion, same cycle as accept:
  - Position p = lowest slot that is invalid or holds a strictly worse entry.
  - Strictly worse: in_value < entry (min mode) or in_value > entry (max mode). Signed compare, full N bits.
  - Slots ≥ p shift down one; slot K-1 falls off. New entry stores value, payload, arrival index.
  - If no such p exists, the list is unchanged.
- Ties: the earlier arrival ranks better (a new equal value never displaces).
- After accept #NUM_VALUES-1, go to DRAIN next cycle.
  - First out_valid appears 1 cycle after the last accept.
  - count wraps to 0.
- DRAIN: present slot r for r = 0..K-1.
  - Advance r on out_valid & out_ready.
  - Outputs are held stable while out_ready = 0.
  - out_last = (r == K-1).
- After the last handshake:
  - Return to ACCUM; in_ready = 1 on the next cycle.
  - List invalidated; busy drops the same edge.
- frame_abort, any state, highest priority:
  - The next edge clears list and count and forces ACCUM with busy = 0.
  - in_valid in that cycle is ignored (no accept).
  - out_valid drops that edge; no out_last is emitted.
- K == NUM_VALUES: full sorted frame is output.
- Unlike the predecessor, the block never accepts a new frame while results are undrained. Back-pressure is via in_ready.
- Reset mid-frame or mid-drain: immediate return to reset values.
- Throughput: NUM_VALUES + K cycles per frame at full rate.

Optional Feature:
- TIE_LAST_EN defined: ties rank the later arrival better. The insertion compare becomes ≤ (min mode) or ≥ (max mode).
- Undefined: earlier arrival wins, as above.

Test Plan:
- Min mode, NUM_VALUES=16, K=3. Values all 100 except idx5 = -3, idx9 = 7, idx12 = -3; out_ready = 1.
  - Expect: rank0 (-3, out_index 6), rank1 (-3, 13), rank2 (7, 10).
  - out_last on rank2. in_ready low for exactly 3 cycles.
- Same stimulus with TIE_LAST_EN defined -> rank0 index 13, rank1 index 6, rank2 index 10.
- Max mode, values 0..15 ascending, K=4 -> 15, 14, 13, 12 with indices 16, 15, 14, 13. Payload = value*3 matches on every result.
- Drain with out_ready toggling 1,0,0,1 -> out_value/out_payload/out_rank stable while stalled. Exactly K handshakes, then in_ready = 1.
- Assert frame_abort after 7 accepts with in_valid high -> that sample is not accepted, busy = 0 next cycle. Next full frame yields correct results unaffected by the aborted samples.
- Pulse rst_n low mid-drain -> all outputs 0, in_ready = 1. Next frame works normally. Run an N = 8 instance with -128 and 127 extremes to check signed compare.
